// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul operand/result scheduler: FSM encoding,
// pipeline offset and width helpers. Also imported by the array testbench.
package matmul_pkg;

  // Scheduler FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_RDY  = 3'd1;
  localparam logic [2:0] ST_FETCH     = 3'd2;
  localparam logic [2:0] ST_FEED_TAIL = 3'd3;
  localparam logic [2:0] ST_DRAIN     = 3'd4;
  localparam logic [2:0] ST_COLLECT   = 3'd5;

  // Cycles from the first operand beat entering the array to the first
  // result column leaving it (skew in, inner dimension, skew out, MAC depth).
  function automatic int sched_res_offset(input int m, input int n, input int l, input int w_up);
    return m + n + l + w_up - 1;
  endfunction

  // Width of the result column index, never narrower than one bit.
  function automatic int sched_cw(input int l);
    return (l > 1) ? $clog2(l) : 1;
  endfunction

  // Width of a counter that must be able to hold max_val.
  function automatic int sched_cnt_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/matmul_sched.sv
// Job scheduler for an output-stationary systolic matrix multiplier: reads
// the operand columns/rows from two 1-cycle-latency RAMs, streams them into
// the array as an unbroken valid burst, waits for the pipeline to drain and
// then collects the result columns (rightmost first).
module matmul_sched
  import matmul_pkg::*;
#(
  parameter int WIDTH_left = 8,
  parameter int WIDTH_up   = 8,
  parameter int WIDTH_out  = 8,
  parameter int Mritx_M    = 3,
  parameter int Mritx_N    = 3,
  parameter int Mritx_L    = 3,
  parameter int ADDR_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              a_rd_en,
  output logic [ADDR_W-1:0]                 a_rd_addr,
  input  logic [Mritx_M*WIDTH_left-1:0]     a_rd_data,
  output logic                              b_rd_en,
  output logic [ADDR_W-1:0]                 b_rd_addr,
  input  logic [Mritx_L*WIDTH_up-1:0]       b_rd_data,
  output logic                              arr_valid,
  output logic [Mritx_M*WIDTH_left-1:0]     arr_left,
  output logic [Mritx_L*WIDTH_up-1:0]       arr_up,
  input  logic                              arr_ready,
  input  logic [Mritx_M*WIDTH_out-1:0]      arr_product,
  output logic                              res_valid,
  output logic [Mritx_M*WIDTH_out-1:0]      res_data,
  output logic [sched_cw(Mritx_L)-1:0]      res_col
);

  localparam int RES_OFFSET = sched_res_offset(Mritx_M, Mritx_N, Mritx_L, WIDTH_up);
  localparam int CW         = sched_cw(Mritx_L);
  localparam int CNT_W      = sched_cnt_w(RES_OFFSET + Mritx_L);

  // The job counter is 0 on the first read cycle, so it equals the number of
  // cycles elapsed since the first read. The first operand beat is at count 1,
  // hence the last drain cycle is at count RES_OFFSET.
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(Mritx_N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RES_OFFSET);
  localparam logic [CW-1:0]    COL_FIRST  = CW'(Mritx_L - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CW-1:0]    col_reg, col_next;
  logic             done_reg, done_next;
  logic             arr_valid_reg;
  genvar            gi;

  // Next-state and counter logic for the job sequence
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        col_next = '0;
        if (start) state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        // Always spend at least one cycle here, even if ready arrived with start
        if (arr_ready) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == FETCH_LAST) state_next = ST_FEED_TAIL;
      end
      ST_FEED_TAIL: begin
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == DRAIN_LAST) begin
          state_next = ST_COLLECT;
          col_next   = COL_FIRST;
        end
      end
      ST_COLLECT: begin
        if (col_reg == '0) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          col_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          col_next = col_reg - CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        col_next   = '0;
      end
    endcase
  end

  // State, counters and the registered strobes; reset abandons any job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      col_reg       <= '0;
      done_reg      <= 1'b0;
      arr_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      col_reg       <= col_next;
      done_reg      <= done_next;
      // Operand beat is valid the cycle the RAM returns the word read last cycle
      arr_valid_reg <= (state_reg == ST_FETCH);
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;

  assign a_rd_en   = (state_reg == ST_FETCH);
  assign b_rd_en   = (state_reg == ST_FETCH);
  assign a_rd_addr = a_rd_en ? ADDR_W'(cnt_reg) : '0;
  assign b_rd_addr = b_rd_en ? ADDR_W'(cnt_reg) : '0;

  assign arr_valid = arr_valid_reg;
  assign res_valid = (state_reg == ST_COLLECT);
  assign res_col   = res_valid ? col_reg : '0;

  // The RAM output register holds the operand word; lanes are forced to zero
  // outside the valid burst so the array never shifts in stale data.
  for (gi = 0; gi < Mritx_M; gi++) begin : g_left
    assign arr_left[gi*WIDTH_left +: WIDTH_left] =
      arr_valid_reg ? a_rd_data[gi*WIDTH_left +: WIDTH_left] : '0;
  end

  for (gi = 0; gi < Mritx_L; gi++) begin : g_up
    assign arr_up[gi*WIDTH_up +: WIDTH_up] =
      arr_valid_reg ? b_rd_data[gi*WIDTH_up +: WIDTH_up] : '0;
  end

  for (gi = 0; gi < Mritx_M; gi++) begin : g_res
    assign res_data[gi*WIDTH_out +: WIDTH_out] =
      res_valid ? arr_product[gi*WIDTH_out +: WIDTH_out] : '0;
  end

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: table of directed jobs plus randomized jobs for the
// default geometry, checked cycle by cycle against a timeline model, and a
// short hand-written job on a 2x4x2 instance.
module tb_matmul_sched;

  localparam int M  = 3;
  localparam int N  = 3;
  localparam int L  = 3;
  localparam int WL = 8;
  localparam int WU = 8;
  localparam int WO = 8;
  localparam int AW = 8;
  localparam int CW = 2;
  localparam int PW = M * WO;
  localparam int RO = M + N + L + WU - 1;   // cycles first operand beat -> first result

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic a_rd_en, b_rd_en, arr_valid, arr_ready, res_valid;
  logic [AW-1:0]   a_rd_addr, b_rd_addr;
  logic [M*WL-1:0] a_rd_data, arr_left;
  logic [L*WU-1:0] b_rd_data, arr_up;
  logic [PW-1:0]   arr_product, res_data;
  logic [CW-1:0]   res_col;

  logic [M*WL-1:0] a_mem [0:(1<<AW)-1];
  logic [L*WU-1:0] b_mem [0:(1<<AW)-1];

  // second instance: 2x4x2
  logic start2, busy2, done2, a_rd_en2, b_rd_en2, arr_valid2, arr_ready2, res_valid2;
  logic [AW-1:0] a_rd_addr2, b_rd_addr2;
  logic [15:0]   a_rd_data2, b_rd_data2, arr_left2, arr_up2, arr_product2, res_data2;
  logic [0:0]    res_col2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int d;            // cycles arr_ready stays low after start
    int restart_at;   // cycle of an extra start pulse (-1 none)
    int rst_at;       // cycle of a mid-job reset (-1 none)
    bit ident;        // A = identity, B = 1..9
    int exp_res;
    int exp_done;
  } job_t;

  job_t tbl [7];

  always #5 clk = ~clk;

  matmul_sched u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .arr_valid(arr_valid), .arr_left(arr_left), .arr_up(arr_up),
    .arr_ready(arr_ready), .arr_product(arr_product),
    .res_valid(res_valid), .res_data(res_data), .res_col(res_col)
  );

  matmul_sched #(.Mritx_M(2), .Mritx_N(4), .Mritx_L(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .a_rd_en(a_rd_en2), .a_rd_addr(a_rd_addr2), .a_rd_data(a_rd_data2),
    .b_rd_en(b_rd_en2), .b_rd_addr(b_rd_addr2), .b_rd_data(b_rd_data2),
    .arr_valid(arr_valid2), .arr_left(arr_left2), .arr_up(arr_up2),
    .arr_ready(arr_ready2), .arr_product(arr_product2),
    .res_valid(res_valid2), .res_data(res_data2), .res_col(res_col2)
  );

  // 1-cycle-latency operand RAMs
  always_ff @(posedge clk) begin
    if (a_rd_en)  a_rd_data  <= a_mem[a_rd_addr];
    if (b_rd_en)  b_rd_data  <= b_mem[b_rd_addr];
    if (a_rd_en2) a_rd_data2 <= {2{8'h10 + a_rd_addr2}};
    if (b_rd_en2) b_rd_data2 <= {2{8'h20 + b_rd_addr2}};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic eb, input logic ed, input logic er,
                         input logic [63:0] eaddr, input logic ev, input logic [63:0] el,
                         input logic [63:0] eu, input logic erv, input logic [63:0] edata,
                         input logic [63:0] ecol);
    chk({tag, "_busy"},      64'(busy),      64'(eb));
    chk({tag, "_done"},      64'(done),      64'(ed));
    chk({tag, "_a_rd_en"},   64'(a_rd_en),   64'(er));
    chk({tag, "_b_rd_en"},   64'(b_rd_en),   64'(er));
    chk({tag, "_a_rd_addr"}, 64'(a_rd_addr), eaddr);
    chk({tag, "_b_rd_addr"}, 64'(b_rd_addr), eaddr);
    chk({tag, "_arr_valid"}, 64'(arr_valid), 64'(ev));
    chk({tag, "_arr_left"},  64'(arr_left),  el);
    chk({tag, "_arr_up"},    64'(arr_up),    eu);
    chk({tag, "_res_valid"}, 64'(res_valid), 64'(erv));
    chk({tag, "_res_data"},  64'(res_data),  edata);
    chk({tag, "_res_col"},   64'(res_col),   ecol);
  endtask

  // One job on the default instance. Cycle 0 is the first cycle after the
  // edge that samples start; reads begin at cycle f = d+1.
  task automatic run_job(input int idx, input int d, input int restart_at, input int rst_at,
                         input bit ident, input int exp_res, input int exp_done);
    int f, dn, n_res, n_done;
    bit ab;
    logic [M*WL-1:0] ta;
    logic [L*WU-1:0] tr;
    logic eb, ed, er, ev, erv;
    logic [63:0] eaddr, el, eu, edata, ecol;
    f = d + 1;
    dn = f + RO + L + 1;
    n_res = 0;
    n_done = 0;
    ab = 1'b0;

    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < M; i++) ta[i*WL +: WL] = ident ? ((i == k) ? 8'd1 : 8'd0) : 8'($urandom);
      for (int j = 0; j < L; j++) tr[j*WU +: WU] = ident ? 8'(L*k + j + 1) : 8'($urandom);
      a_mem[k] = ta;
      b_mem[k] = tr;
    end
    start = 1'b1;
    arr_ready = (d == 0);
    arr_product = PW'($urandom);
    @(negedge clk);
    chk("pre_busy", 64'(busy), 64'(0));
    chk("pre_done", 64'(done), 64'(0));

    for (int j = 0; j <= dn; j++) begin
      @(posedge clk); #1;
      start = (j == restart_at);
      if (j < d)      arr_ready = 1'b0;
      else if (j < f) arr_ready = 1'b1;
      else            arr_ready = 1'($urandom_range(0, 1));
      arr_product = PW'($urandom);
      if (j == rst_at) begin
        rst = 1'b1;
        ab = 1'b1;
        #1;
        chk_all("rst_now", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
      eb    = !ab && (j <= f + RO + L);
      ed    = !ab && (j == dn);
      er    = !ab && (j >= f) && (j < f + N);
      eaddr = er ? 64'(j - f) : 64'(0);
      ev    = !ab && (j >= f + 1) && (j <= f + N);
      el    = ev ? 64'(a_mem[j-f-1]) : 64'(0);
      eu    = ev ? 64'(b_mem[j-f-1]) : 64'(0);
      erv   = !ab && (j >= f + RO + 1) && (j <= f + RO + L);
      edata = erv ? 64'(arr_product) : 64'(0);
      ecol  = erv ? 64'(L - 1 - (j - f - RO - 1)) : 64'(0);
      chk_all("cyc", eb, ed, er, eaddr, ev, el, eu, erv, edata, ecol);
      if (res_valid) n_res++;
      if (done) n_done++;
      rst = 1'b0;
    end
    chk("res_beats", 64'(n_res), 64'(exp_res));
    chk("done_pulses", 64'(n_done), 64'(exp_done));
    $display("job %0d: ready_delay=%0d restart_at=%0d rst_at=%0d res_beats=%0d done_pulses=%0d",
             idx, d, restart_at, rst_at, n_res, n_done);
  endtask

  initial begin
    int nreads2, nv2, nr2, nd2, fv2, fr2;
    int d, ra;
    logic [7:0] v8;

    rst = 1'b1;
    start = 1'b0;
    arr_ready = 1'b0;
    arr_product = '0;
    start2 = 1'b0;
    arr_ready2 = 1'b0;
    arr_product2 = 16'hbeef;
    for (int k = 0; k < (1 << AW); k++) begin
      a_mem[k] = '0;
      b_mem[k] = '0;
    end

    tbl[0] = '{0, -1, -1, 1'b1, 3, 1};   // identity x 1..9, ready with start
    tbl[1] = '{5, -1, -1, 1'b1, 3, 1};   // ready late by 5 cycles
    tbl[2] = '{0,  7, -1, 1'b0, 3, 1};   // start re-pulsed during DRAIN
    tbl[3] = '{0, -1,  2, 1'b0, 0, 0};   // reset during FETCH
    tbl[4] = '{0, -1, -1, 1'b0, 3, 1};   // fresh job after reset
    tbl[5] = '{0, -1, -1, 1'b0, 3, 1};   // back-to-back with previous
    tbl[6] = '{3, 12, -1, 1'b0, 3, 1};

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy2", 64'(busy2), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 7; t++)
      run_job(t, tbl[t].d, tbl[t].restart_at, tbl[t].rst_at, tbl[t].ident,
              tbl[t].exp_res, tbl[t].exp_done);

    for (int r = 0; r < 8; r++) begin
      d  = int'($urandom_range(0, 6));
      ra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, d + 1 + RO + L)) : -1;
      run_job(100 + r, d, ra, -1, 1'b0, 3, 1);
    end

    // 2x4x2 instance: 4 reads, 15-cycle offset, 2 result beats
    nreads2 = 0; nv2 = 0; nr2 = 0; nd2 = 0; fv2 = -1; fr2 = -1;
    @(posedge clk); #1;
    start2 = 1'b1;
    arr_ready2 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start2 = 1'b0;
      @(negedge clk);
      if (a_rd_en2) begin
        chk("d2_addr", 64'(a_rd_addr2), 64'(nreads2));
        nreads2++;
      end
      if (arr_valid2) begin
        if (fv2 < 0) fv2 = c;
        v8 = 8'h10 + 8'(nv2);
        chk("d2_left", 64'(arr_left2), 64'({v8, v8}));
        v8 = 8'h20 + 8'(nv2);
        chk("d2_up", 64'(arr_up2), 64'({v8, v8}));
        nv2++;
      end
      if (res_valid2) begin
        if (fr2 < 0) fr2 = c;
        chk("d2_col", 64'(res_col2), 64'(1 - nr2));
        chk("d2_data", 64'(res_data2), 64'(16'hbeef));
        nr2++;
      end
      if (done2) nd2++;
    end
    chk("d2_reads", 64'(nreads2), 64'(4));
    chk("d2_valid_beats", 64'(nv2), 64'(4));
    chk("d2_offset", 64'(fr2 - fv2), 64'(15));
    chk("d2_res_beats", 64'(nr2), 64'(2));
    chk("d2_done", 64'(nd2), 64'(1));
    chk("d2_idle", 64'(busy2), 64'(0));
    $display("job 2x4x2: reads=%0d valid_beats=%0d offset=%0d res_beats=%0d done_pulses=%0d",
             nreads2, nv2, fr2 - fv2, nr2, nd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
